data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder: the slave end of the core's data bus (MREQ/WRITE/SIZE/DAD/DDT/ACKD_n). It latches a request, inserts a programmable number of wait states, performs a byte/half/word read or write into an internal word-organised RAM, and acknowledges with a one-cycle active-low ACKD_n. It sits between the CPU core and the testbench/top-level, replacing the behavioural memory model.

## Interface
- ADDR_BASE, 32'h0000_0000, byte address of word 0 of the RAM
- DEPTH_WORDS, 1024, number of 32-bit words (power of two)
- WAIT_CYCLES, 1, wait states between request sample and acknowledge (0..15)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- MREQ  in  1  request valid, held by the requester until ACKD_n is sampled low
- WRITE  in  1  1 = store, 0 = load; valid with MREQ
- SIZE  in  2  00 word, 01 half, 10 byte, 11 illegal
- DAD  in  32  byte address
- DDT  inout  32  store data in (lane 0 aligned); load data out (driven only in ACK of a read)
- ACKD_n  out  1  transfer complete, active-low, one cycle
- BERR_n  out  1  bus error, active-low, asserted only together with ACKD_n

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: MREQ sampled 1 -> latch DAD, SIZE, WRITE, DDT; go WAIT (counter = WAIT_CYCLES) if WAIT_CYCLES>0, else ACK.
- WAIT: counter decrements each cycle; at counter==1 go ACK. MREQ/DAD changes ignored (latched copies used).
- ACK: ACKD_n=0 for exactly one cycle; unconditionally return to IDLE. MREQ in the ACK cycle is not sampled.
- Error check on latched request: SIZE==11, word with addr[1:0]!=0, half with addr[0]!=0, or addr outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS). Error -> no RAM write, read data 0, BERR_n=0 in ACK cycle.
- Little-endian lanes. Word index = (addr-ADDR_BASE)>>2, lane = addr[1:0].
- Store: byte writes DDT[7:0] to lane; half writes DDT[15:0] to lanes {addr[1],0}+1..0; word writes all. Other lanes untouched (byte-enable write).
- Load: selected bytes shifted to DDT[7:0]/[15:0], zero-extended; sign extension belongs to the core.
- DDT drive: output enable = (state==ACK) && !WRITE_latched; otherwise high-Z.

## Timing
- Reset: state IDLE, ACKD_n=1, BERR_n=1, DDT high-Z, counter 0. RAM contents not reset.
- Request sampled at edge E0 -> ACKD_n low in the cycle after edge E0+WAIT_CYCLES; total latency WAIT_CYCLES+1 cycles.
- Store committed at the edge that enters ACK; read data valid for the whole ACK cycle.
- Back-to-back: MREQ still 1 at the first IDLE edge after ACK starts a new transfer; minimum spacing WAIT_CYCLES+2 cycles.
- Reset asserted before the edge entering ACK: request discarded, no write. Reset during ACK: write already committed; ACKD_n/BERR_n return to 1 immediately (async).
- Counter is 4 bits; WAIT_CYCLES>15 is a parameter error (elaboration check).

## Configuration
- DMEM_WAIT_EN defined: WAIT state and counter present; WAIT_CYCLES honoured.
- DMEM_WAIT_EN undefined: WAIT state and counter removed; IDLE -> ACK always (latency 1); WAIT_CYCLES ignored.

## Structure
- Package dmem_pkg: state encoding (IDLE/WAIT/ACK), SIZE encodings SZ_WORD/SZ_HALF/SZ_BYTE, error-check and lane-mask functions.
- Sub-module dmem_lane_align: combinational; from size, addr[1:0], store data and RAM word produces 4-bit byte enable, lane-shifted write data, aligned zero-extended read data, misalign flag.
- Top: FSM, wait counter, request latches, RAM array, DDT tristate.

## Test plan
- WAIT_CYCLES=2, word store 0xDEADBEEF @0x10, then word load @0x10 -> ACKD_n low 3 cycles after each request, DDT=0xDEADBEEF, BERR_n=1.
- Byte store 0xAA @0x13 over 0xDEADBEEF, word load @0x10 -> 0xAAADBEEF; byte load @0x13 -> 0x000000AA.
- Half store 0x1234 @0x12, half load @0x12 -> 0x00001234; word load @0x10 -> 0x1234BEEF.
- Word load @0x11, half store @0x13, SIZE=11 @0x10, word load @0x1000 -> each ACKD_n=BERR_n=0, DDT=0, RAM unchanged.
- Store @0x20 with rst pulsed low during WAIT -> ACKD_n stays 1, later load @0x20 returns prior value.
- DMEM_WAIT_EN undefined, MREQ held high for two loads -> ACKD_n low 1 cycle after each sample, IDLE cycle between acks.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// The optional wait-state logic in the top is controlled by the DMEM_WAIT_EN macro.
package dmem_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACK  = 2'd2;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // One bus transfer as latched from the requester
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dmem_req_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_WORD: m = 4'b1111;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: m = 4'b0001 << lane;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_WORD: mis = (lane != 2'b00);
      SZ_HALF: mis = lane[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // 33-bit arithmetic so a window ending at 4 GiB does not wrap
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input logic [ADDR_W-1:0] base,
                                             input logic [ADDR_W:0]   span_bytes);
    logic [ADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr < base) || (off >= span_bytes);
  endfunction

  function automatic logic req_error(input logic [1:0] size, input logic misalign,
                                     input logic out_of_range);
    return (size == SZ_ILLEGAL) || misalign || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering between the 32-bit bus and the word-wide RAM.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ram_word,
  output logic [3:0]        be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misalign_c
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    be_c       = lane_mask(size, lane);
    misalign_c = misaligned(size, lane);
    wdata_c    = st_data << {lane, 3'b000};
    shifted    = ram_word >> {lane, 3'b000};
    rdata_c    = '0;
    // Word accesses are only legal at lane 0, so the shift is a no-op for them
    case (size)
      SZ_WORD: rdata_c = shifted;
      SZ_HALF: rdata_c = {16'h0000, shifted[15:0]};
      SZ_BYTE: rdata_c = {24'h000000, shifted[7:0]};
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus slave: latches a request, optional wait states, byte-enable RAM access, one-cycle ACKD_n.
// Wait-state counter is present only when DMEM_WAIT_EN is defined; otherwise latency is one cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  logic [31:0] DDT,
  output logic        ACKD_n,
  output logic        BERR_n
);

  localparam int unsigned    IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  generate
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_mem_responder: WAIT_CYCLES must be 0..15");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
  endgenerate

  logic [STATE_W-1:0] state_q, state_d;
`ifdef DMEM_WAIT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif
  dmem_req_t          req_q, req_d;
  dmem_req_t          cur_c;
  logic               ackd_n_q, ackd_n_d;
  logic               berr_n_q, berr_n_d;
  logic               ddt_oe_q, ddt_oe_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]   idx_c;
  logic [DATA_W-1:0]  ram_word_c;
  logic [3:0]         be_c;
  logic [DATA_W-1:0]  wdata_c;
  logic [DATA_W-1:0]  rdata_al_c;
  logic               misalign_c;
  logic               err_c;
  logic               enter_ack_c;
  logic               we_c;

  // In IDLE the live bus is the request; afterwards only the latched copy counts
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_c.write = WRITE;
      cur_c.size  = SIZE;
      cur_c.addr  = DAD;
      cur_c.data  = DDT;
    end else begin
      cur_c = req_q;
    end
  end

  always_comb begin
    idx_c      = IDX_W'((cur_c.addr - ADDR_BASE) >> 2);
    ram_word_c = mem_q[idx_c];
  end

  dmem_lane_align u_lane_align (
    .size       (cur_c.size),
    .lane       (cur_c.addr[1:0]),
    .st_data    (cur_c.data),
    .ram_word   (ram_word_c),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .rdata_c    (rdata_al_c),
    .misalign_c (misalign_c)
  );

  always_comb begin
    err_c = req_error(cur_c.size, misalign_c,
                      addr_out_of_range(cur_c.addr, ADDR_BASE, SPAN_BYTES));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
`ifdef DMEM_WAIT_EN
    cnt_d    = cnt_q;
`endif
    req_d    = req_q;
    ackd_n_d = 1'b1;
    berr_n_d = 1'b1;
    ddt_oe_d = 1'b0;
    rdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          req_d = cur_c;
`ifdef DMEM_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d = ST_ACK;
          end
`else
          state_d = ST_ACK;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    enter_ack_c = (state_d == ST_ACK) && (state_q != ST_ACK);
    if (enter_ack_c) begin
      ackd_n_d = 1'b0;
      berr_n_d = !err_c;
      ddt_oe_d = !cur_c.write;
      rdata_d  = err_c ? '0 : rdata_al_c;
    end
    // RAM has no reset, so a request seen while rst is low must not write
    we_c = enter_ack_c && cur_c.write && !err_c && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
`ifdef DMEM_WAIT_EN
      cnt_q    <= '0;
`endif
      req_q    <= '0;
      ackd_n_q <= 1'b1;
      berr_n_q <= 1'b1;
      ddt_oe_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
`ifdef DMEM_WAIT_EN
      cnt_q    <= cnt_d;
`endif
      req_q    <= req_d;
      ackd_n_q <= ackd_n_d;
      berr_n_q <= berr_n_d;
      ddt_oe_q <= ddt_oe_d;
      rdata_q  <= rdata_d;
    end
  end

  // Byte-enable store; commits at the edge that enters ACK
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  assign ACKD_n = ackd_n_q;
  assign BERR_n = berr_n_q;
  assign DDT    = ddt_oe_q ? rdata_q : 32'bz;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected acks queued at request time, checked on ACKD_n.
module tb_data_mem_responder;

`ifdef DMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  typedef struct {
    string       name;
    int          cyc;
    logic        berr_n;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mreq = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] dad = '0;
  logic [31:0] ddt_drv = '0;
  logic        ddt_en = 1'b0;
  wire  [31:0] ddt_w;
  logic        ackd_n, berr_n;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  assign ddt_w = ddt_en ? ddt_drv : 32'bz;

  data_mem_responder #(
    .ADDR_BASE   (32'h0000_0000),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .MREQ   (mreq),
    .WRITE  (write),
    .SIZE   (size),
    .DAD    (dad),
    .DDT    (ddt_w),
    .ACKD_n (ackd_n),
    .BERR_n (berr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && ackd_n === 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack: ACKD_n low at cycle %0d, required no ack", cyc);
      end else begin
        mon_e = sb.pop_front();
        n_chk++;
        if (cyc !== mon_e.cyc) begin
          n_fail++;
          $display("FAIL %s latency: ack at cycle %0d, required %0d", mon_e.name, cyc, mon_e.cyc);
        end
        n_chk++;
        if (berr_n !== mon_e.berr_n) begin
          n_fail++;
          $display("FAIL %s berr: BERR_n=%b, required %b", mon_e.name, berr_n, mon_e.berr_n);
        end
        if (mon_e.chk_data) begin
          n_chk++;
          if (ddt_w !== mon_e.data) begin
            n_fail++;
            $display("FAIL %s data: DDT=%h, required %h", mon_e.name, ddt_w, mon_e.data);
          end
        end
      end
    end
  end

  // Drive one transfer, queue its expectation, hold MREQ until the ack is seen
  task automatic bus_xfer(input string nm, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_berr_n, input logic [31:0] exp_rd);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.name = nm; e.cyc = cyc + 1 + W; e.berr_n = exp_berr_n;
    e.chk_data = !wr; e.data = exp_rd;
    sb.push_back(e);
    mreq = 1'b1; write = wr; size = sz; dad = addr;
    ddt_drv = wd; ddt_en = wr;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ackd_n === 1'b0) got = 1'b1;
    end
    mreq = 1'b0; write = 1'b0; ddt_en = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no ack within 40 cycles, required ack", nm);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ddt_drv = 32'h5A5A_5A5A; ddt_en = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (ackd_n !== 1'b1) begin n_fail++; $display("FAIL reset_ackd: ACKD_n=%b, required 1", ackd_n); end
    n_chk++;
    if (berr_n !== 1'b1) begin n_fail++; $display("FAIL reset_berr: BERR_n=%b, required 1", berr_n); end
    n_chk++;
    if (ddt_w !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL reset_ddt: DDT=%h, required %h", ddt_w, 32'h5A5A_5A5A);
    end
    ddt_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    bus_xfer("st_w10", 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0);
    bus_xfer("ld_w10", 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
    bus_xfer("st_w00", 1'b1, 2'b00, 32'h00, 32'h0102_0304, 1'b1, 32'h0);
    bus_xfer("st_w20", 1'b1, 2'b00, 32'h20, 32'h1122_3344, 1'b1, 32'h0);
    bus_xfer("ld_w20", 1'b0, 2'b00, 32'h20, 32'h0, 1'b1, 32'h1122_3344);
  endtask

  task automatic test_byte;
    bus_xfer("st_b13", 1'b1, 2'b10, 32'h13, 32'h0000_00AA, 1'b1, 32'h0);
    bus_xfer("ld_w10_b", 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 32'hAAAD_BEEF);
    bus_xfer("ld_b13", 1'b0, 2'b10, 32'h13, 32'h0, 1'b1, 32'h0000_00AA);
  endtask

  task automatic test_half;
    bus_xfer("st_h12", 1'b1, 2'b01, 32'h12, 32'h0000_1234, 1'b1, 32'h0);
    bus_xfer("ld_h12", 1'b0, 2'b01, 32'h12, 32'h0, 1'b1, 32'h0000_1234);
    bus_xfer("ld_w10_h", 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 32'h1234_BEEF);
    bus_xfer("ld_b12", 1'b0, 2'b10, 32'h12, 32'h0, 1'b1, 32'h0000_0034);
    bus_xfer("ld_h10", 1'b0, 2'b01, 32'h10, 32'h0, 1'b1, 32'h0000_BEEF);
  endtask

  task automatic test_errors;
    bus_xfer("err_ld_w11", 1'b0, 2'b00, 32'h11, 32'h0, 1'b0, 32'h0);
    bus_xfer("err_st_h13", 1'b1, 2'b01, 32'h13, 32'h0000_FFFF, 1'b0, 32'h0);
    bus_xfer("err_sz11", 1'b0, 2'b11, 32'h10, 32'h0, 1'b0, 32'h0);
    bus_xfer("err_ld_1000", 1'b0, 2'b00, 32'h1000, 32'h0, 1'b0, 32'h0);
    bus_xfer("err_st_1000", 1'b1, 2'b00, 32'h1000, 32'hBAD0_BAD0, 1'b0, 32'h0);
    bus_xfer("post_err_w10", 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 32'h1234_BEEF);
    bus_xfer("post_err_w00", 1'b0, 2'b00, 32'h00, 32'h0, 1'b1, 32'h0102_0304);
  endtask

`ifdef DMEM_WAIT_EN
  task automatic test_reset_wait;
    @(negedge clk);
    mreq = 1'b1; write = 1'b1; size = 2'b00; dad = 32'h20;
    ddt_drv = 32'h5566_7788; ddt_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    mreq = 1'b0; write = 1'b0; ddt_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      n_chk++;
      if (ackd_n !== 1'b1) begin
        n_fail++; $display("FAIL rst_wait_ack: ACKD_n=%b at step %0d, required 1", ackd_n, i);
      end
    end
    bus_xfer("ld_w20_rst", 1'b0, 2'b00, 32'h20, 32'h0, 1'b1, 32'h1122_3344);
  endtask
`endif

  task automatic test_reset_ack;
    exp_t e;
    bit   got;
    @(negedge clk);
    e.name = "st_w24_rst"; e.cyc = cyc + 1 + W; e.berr_n = 1'b1; e.chk_data = 1'b0; e.data = '0;
    sb.push_back(e);
    mreq = 1'b1; write = 1'b1; size = 2'b00; dad = 32'h24;
    ddt_drv = 32'hCAFE_F00D; ddt_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ackd_n === 1'b0) got = 1'b1;
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL rst_ack_timeout: no ack, required ack"); sb.delete(); end
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if (ackd_n !== 1'b1 || berr_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_ack_async: ACKD_n=%b BERR_n=%b, required 1 1", ackd_n, berr_n);
    end
    mreq = 1'b0; write = 1'b0; ddt_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_xfer("ld_w24", 1'b0, 2'b00, 32'h24, 32'h0, 1'b1, 32'hCAFE_F00D);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   got;
    int   k;
    @(negedge clk);
    k = cyc + 1;
    e.name = "b2b_first"; e.cyc = k + W; e.berr_n = 1'b1; e.chk_data = 1'b1; e.data = 32'h1234_BEEF;
    sb.push_back(e);
    e.name = "b2b_second"; e.cyc = k + 2 * W + 2; e.data = 32'h0102_0304;
    sb.push_back(e);
    mreq = 1'b1; write = 1'b0; size = 2'b00; dad = 32'h10;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ackd_n === 1'b0) got = 1'b1;
    end
    dad = 32'h00;
    @(negedge clk);
    n_chk++;
    if (ackd_n !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap: ACKD_n=%b, required 1", ackd_n); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ackd_n === 1'b0) got = 1'b1;
      else @(negedge clk);
    end
    mreq = 1'b0;
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL b2b_timeout: second ack missing, required ack"); sb.delete(); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
`ifdef DMEM_WAIT_EN
    test_reset_wait();
`endif
    test_reset_ack();
    test_back_to_back();
    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
